// File: rtl/lab1_sweep_ctrl.sv
// rtl/lab1_sweep_ctrl.sv - on-chip 16-vector sweep and cross-check of the Lab1 F(A,B,C,D) implementations
// Optional feature macro: LAB1_SWEEP_STOP_ON_ERR_EN (end the sweep at the first disagreeing vector)
module lab1_sweep_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_VEC     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic [2:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_bad,
    output logic        first_bad_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] LAST_IDX    = 4'(NUM_VEC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic [7:0] hold;
    logic       vec_bad;
    logic       last_vec;
    logic       stop_now;
    logic       launch;

    // The three implementations agree only when their outputs are all 0 or all 1.
    assign vec_bad  = (f_in != 3'b000) && (f_in != 3'b111);
    assign last_vec = (idx == LAST_IDX);
    assign launch   = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef LAB1_SWEEP_STOP_ON_ERR_EN
    assign stop_now = vec_bad;
`else
    assign stop_now = 1'b0;
`endif

    // idx is 0 in IDLE, and in DONE it rests on the last vector (4'hF) or the failing one.
    assign abcd = idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                busy = 1'b1;
                if (hold == 8'd0) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (last_vec || stop_now) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = S_DRIVE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Vector index, hold counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= 4'd0;
            hold          <= 8'd0;
            truth         <= 16'd0;
            mismatch_cnt  <= 5'd0;
            first_bad     <= 4'd0;
            first_bad_vld <= 1'b0;
        end else if (launch) begin
            idx           <= 4'd0;
            hold          <= HOLD_RELOAD;
            truth         <= 16'd0;
            mismatch_cnt  <= 5'd0;
            first_bad_vld <= 1'b0;
        end else if (state == S_DRIVE) begin
            if (hold != 8'd0) begin
                hold <= hold - 8'd1;
            end
        end else if (state == S_SAMPLE) begin
            truth[idx] <= f_in[0];
            if (vec_bad) begin
                mismatch_cnt <= mismatch_cnt + 5'd1;
                if (!first_bad_vld) begin
                    first_bad     <= idx;
                    first_bad_vld <= 1'b1;
                end
            end
            if (!(last_vec || stop_now)) begin
                idx  <= idx + 4'd1;
                hold <= HOLD_RELOAD;
            end
        end
    end

endmodule

// File: tb/tb_lab1_sweep_ctrl.sv
// tb/tb_lab1_sweep_ctrl.sv - directed self-checking bench for lab1_sweep_ctrl
module tb_lab1_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start1;
    logic [3:0]  abcd;
    logic [3:0]  abcd1;
    logic [2:0]  f_in;
    logic [2:0]  f_in1;
    logic        busy;
    logic        busy1;
    logic        done;
    logic        done1;
    logic [15:0] truth;
    logic [15:0] truth1;
    logic [4:0]  mismatch_cnt;
    logic [4:0]  mismatch_cnt1;
    logic [3:0]  first_bad;
    logic [3:0]  first_bad1;
    logic        first_bad_vld;
    logic        first_bad_vld1;
    logic [15:0] inv2;

    int n_chk;
    int n_fail;
    int cyc;
    int bad_seq;

    // F = A&B | ~C&D ; truth table by hand: vectors 1,5,9,12,13,14,15 -> 16'hF222
    function automatic logic f_model(input logic [3:0] v);
        return (v[3] & v[2]) | (~v[1] & v[0]);
    endfunction

    assign f_in  = {f_model(abcd) ^ inv2[abcd], f_model(abcd), f_model(abcd)};
    assign f_in1 = {3{f_model(abcd1)}};

    lab1_sweep_ctrl #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abcd(abcd), .f_in(f_in),
        .busy(busy), .done(done), .truth(truth), .mismatch_cnt(mismatch_cnt),
        .first_bad(first_bad), .first_bad_vld(first_bad_vld)
    );

    lab1_sweep_ctrl #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abcd(abcd1), .f_in(f_in1),
        .busy(busy1), .done(done1), .truth(truth1), .mismatch_cnt(mismatch_cnt1),
        .first_bad(first_bad1), .first_bad_vld(first_bad_vld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start, then count negedges until done; optionally re-pulse start at cycle poke.
    task automatic run_sweep(input int poke, input string tag, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_cleared_cnt"}, 32'(mismatch_cnt), 32'd0);
        check({tag, "_cleared_vld"}, 32'(first_bad_vld), 32'd0);
        cycles = 0;
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
            start = (cycles == poke);
        end
        start = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        inv2   = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abcd", 32'(abcd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_truth", 32'(truth), 32'd0);
        check("rst_cnt", 32'(mismatch_cnt), 32'd0);
        check("rst_vld", 32'(first_bad_vld), 32'd0);

        // Clean sweep: all implementations agree
        run_sweep(-1, "t2", cyc);
        check("t2_done_cycle", 32'(cyc), 32'd80);
        check("t2_truth", 32'(truth), 32'hF222);
        check("t2_cnt", 32'(mismatch_cnt), 32'd0);
        check("t2_vld", 32'(first_bad_vld), 32'd0);
        check("t2_abcd_done", 32'(abcd), 32'hF);
        check("t2_busy_done", 32'(busy), 32'd0);

`ifndef LAB1_SWEEP_STOP_ON_ERR_EN
        // F3 wrong at vectors 5 and 12
        inv2 = 16'h1020;
        run_sweep(-1, "t3", cyc);
        check("t3_done_cycle", 32'(cyc), 32'd80);
        check("t3_cnt", 32'(mismatch_cnt), 32'd2);
        check("t3_first_bad", 32'(first_bad), 32'd5);
        check("t3_vld", 32'(first_bad_vld), 32'd1);
        check("t3_truth", 32'(truth), 32'hF222);
        inv2 = 16'h0000;
`else
        // Stop on the first error at vector 9: 10 vectors x 5 cycles
        inv2 = 16'h0200;
        run_sweep(-1, "t6", cyc);
        check("t6_done_cycle", 32'(cyc), 32'd50);
        check("t6_abcd", 32'(abcd), 32'd9);
        check("t6_cnt", 32'(mismatch_cnt), 32'd1);
        check("t6_first_bad", 32'(first_bad), 32'd9);
        check("t6_truth", 32'(truth), 32'h0222);
        inv2 = 16'h0000;
`endif

        // Restart from DONE clears results; start at cycle 30 is ignored
        run_sweep(30, "t4", cyc);
        check("t4_done_cycle", 32'(cyc), 32'd80);
        check("t4_cnt", 32'(mismatch_cnt), 32'd0);
        check("t4_truth", 32'(truth), 32'hF222);

        // Reset while vector 7 is driven
        inv2 = 16'h0002;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(abcd == 4'd7 && busy) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("t1_reach_idx7", 32'(abcd), 32'd7);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        inv2 = 16'h0000;
        @(negedge clk);
        check("t1_abcd", 32'(abcd), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_done", 32'(done), 32'd0);
        check("t1_truth", 32'(truth), 32'd0);
        check("t1_cnt", 32'(mismatch_cnt), 32'd0);
        check("t1_first_bad", 32'(first_bad), 32'd0);
        check("t1_vld", 32'(first_bad_vld), 32'd0);

        // HOLD_CYCLES=1: each vector shown for 2 cycles, 32 cycles total
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1  = 1'b0;
        bad_seq = 0;
        cyc     = 0;
        while (!done1 && cyc < 300) begin
            if (cyc < 32 && abcd1 != 4'(cyc / 2)) bad_seq++;
            @(negedge clk);
            cyc++;
        end
        check("t5_abcd_seq_errs", 32'(bad_seq), 32'd0);
        check("t5_done_cycle", 32'(cyc), 32'd32);
        check("t5_truth", 32'(truth1), 32'hF222);
        check("t5_cnt", 32'(mismatch_cnt1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
